// File: rtl/oled_text_sched.sv
// OLED text scheduler: 4x16 shadow buffer, dirty-row tracking, controller handshake sequencing.
// Latency: host access acked one cycle after cs; repaints start at most once per REFRESH_CYCLES.
// Backpressure: host is never stalled; controller ops wait on *_ready with an ACK_TIMEOUT fallback.
module oled_text_sched #(
    parameter int REFRESH_CYCLES = 5000000,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic [5:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       ack,
    input  logic       en,
    output logic       busy,
    output logic       disp_is_on,
    output logic       disp_on_start,
    input  logic       disp_on_ready,
    output logic       disp_off_start,
    input  logic       disp_off_ready,
    output logic       write_start,
    output logic [7:0] write_ascii_data,
    output logic [8:0] write_base_addr,
    input  logic       write_ready,
    output logic       update_start,
    output logic       update_clear,
    input  logic       update_ready
);

    typedef enum logic [3:0] {
        OFF, ON_ACK, ON_WT, IDLE, SEL, WR, WR_ACK, WR_WT,
        UPD_ACK, UPD_WT, OFF_ACK, OFF_WT
    } state_t;

    localparam logic [31:0] REFRESH_RELOAD = 32'(REFRESH_CYCLES - 1);
    localparam logic [15:0] ACK_LAST       = 16'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  mem_q [64];
    logic [7:0]  mem_d [64];
    logic [3:0]  dirty_q, dirty_d;
    logic [31:0] refresh_q, refresh_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic        ack_q, ack_d;
    logic [7:0]  dout_q, dout_d;
    logic        disp_is_on_q, disp_is_on_d;
    logic        disp_on_start_q, disp_on_start_d;
    logic        disp_off_start_q, disp_off_start_d;
    logic        write_start_q, write_start_d;
    logic        update_start_q, update_start_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [8:0]  waddr_q, waddr_d;

    logic [3:0]  host_set;
    logic [3:0]  dirty_clr;
    logic        dirty_all;
    logic        ready_sel;
    logic        in_ack;
    logic        in_wt;
    logic        ack_to_wt;
    logic        op_done;

    // Host port: writes land in the buffer and mark their row dirty; reads return registered data.
    always_comb begin
        mem_d    = mem_q;
        ack_d    = cs;
        dout_d   = dout_q;
        host_set = 4'h0;
        if (cs) begin
            if (we) begin
                mem_d[addr]          = din;
                host_set[addr[5:4]]  = 1'b1;
            end else begin
                dout_d = mem_q[addr];
            end
        end
    end

    // Shared handshake decode: pick the ready of the op in flight and flag ack->wait or completion.
    always_comb begin
        ready_sel = 1'b1;
        case (state_q)
            ON_ACK,  ON_WT:  ready_sel = disp_on_ready;
            OFF_ACK, OFF_WT: ready_sel = disp_off_ready;
            WR_ACK,  WR_WT:  ready_sel = write_ready;
            UPD_ACK, UPD_WT: ready_sel = update_ready;
            default:         ready_sel = 1'b1;
        endcase
        in_ack    = state_q inside {ON_ACK, WR_ACK, UPD_ACK, OFF_ACK};
        in_wt     = state_q inside {ON_WT, WR_WT, UPD_WT, OFF_WT};
        ack_to_wt = in_ack && !ready_sel;
        // A controller that never drops ready is treated as having finished instantly.
        op_done   = ready_sel && (in_wt || (in_ack && (tmo_q == ACK_LAST)));
    end

    // Sequencer next-state: power on/off, row selection, per-character writes and the final update.
    always_comb begin
        state_d          = state_q;
        row_d            = row_q;
        col_d            = col_q;
        tmo_d            = in_ack ? (tmo_q + 16'd1) : 16'd0;
        refresh_d        = (refresh_q != 32'd0) ? (refresh_q - 32'd1) : 32'd0;
        disp_is_on_d     = disp_is_on_q;
        disp_on_start_d  = 1'b0;
        disp_off_start_d = 1'b0;
        write_start_d    = 1'b0;
        update_start_d   = 1'b0;
        wdata_d          = wdata_q;
        waddr_d          = waddr_q;
        dirty_clr        = 4'h0;
        dirty_all        = 1'b0;
        case (state_q)
            OFF: begin
                if (en && disp_on_ready) begin
                    disp_on_start_d = 1'b1;
                    state_d         = ON_ACK;
                end
            end
            ON_ACK, ON_WT: begin
                if (ack_to_wt) begin
                    state_d = ON_WT;
                end else if (op_done) begin
                    dirty_all    = 1'b1;
                    disp_is_on_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            IDLE: begin
                if (!en && disp_off_ready) begin
                    disp_is_on_d     = 1'b0;
                    disp_off_start_d = 1'b1;
                    state_d          = OFF_ACK;
                end else if ((dirty_q != 4'h0) && (refresh_q == 32'd0)) begin
                    refresh_d = REFRESH_RELOAD;
                    state_d   = SEL;
                end
            end
            SEL: begin
                if (dirty_q[0])      row_d = 2'd0;
                else if (dirty_q[1]) row_d = 2'd1;
                else if (dirty_q[2]) row_d = 2'd2;
                else                 row_d = 2'd3;
                dirty_clr = 4'b0001 << row_d;
                col_d     = 4'd0;
                state_d   = WR;
            end
            WR: begin
                // Data and address are captured here and held until the write completes.
                wdata_d       = mem_q[{row_q, col_q}];
                waddr_d       = {row_q, col_q, 3'b000};
                write_start_d = 1'b1;
                state_d       = WR_ACK;
            end
            WR_ACK, WR_WT: begin
                if (ack_to_wt) begin
                    state_d = WR_WT;
                end else if (op_done) begin
                    if (col_q != 4'd15) begin
                        col_d   = col_q + 4'd1;
                        state_d = WR;
                    end else if (dirty_q != 4'h0) begin
                        state_d = SEL;
                    end else begin
                        update_start_d = 1'b1;
                        state_d        = UPD_ACK;
                    end
                end
            end
            UPD_ACK, UPD_WT: begin
                if (ack_to_wt)    state_d = UPD_WT;
                else if (op_done) state_d = IDLE;
            end
            OFF_ACK, OFF_WT: begin
                if (ack_to_wt)    state_d = OFF_WT;
                else if (op_done) state_d = OFF;
            end
            default: state_d = OFF;
        endcase
        // Host set is applied last so a write colliding with a clear keeps the row dirty.
        dirty_d = ((dirty_q & ~dirty_clr) | (dirty_all ? 4'hF : 4'h0)) | host_set;
    end

    // State and datapath registers; reset restores a blank (space-filled) buffer and an idle controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= OFF;
            for (int i = 0; i < 64; i++) mem_q[i] <= 8'h20;
            dirty_q          <= 4'h0;
            refresh_q        <= 32'd0;
            tmo_q            <= 16'd0;
            row_q            <= 2'd0;
            col_q            <= 4'd0;
            ack_q            <= 1'b0;
            dout_q           <= 8'h00;
            disp_is_on_q     <= 1'b0;
            disp_on_start_q  <= 1'b0;
            disp_off_start_q <= 1'b0;
            write_start_q    <= 1'b0;
            update_start_q   <= 1'b0;
            wdata_q          <= 8'h00;
            waddr_q          <= 9'h000;
        end else begin
            state_q          <= state_d;
            mem_q            <= mem_d;
            dirty_q          <= dirty_d;
            refresh_q        <= refresh_d;
            tmo_q            <= tmo_d;
            row_q            <= row_d;
            col_q            <= col_d;
            ack_q            <= ack_d;
            dout_q           <= dout_d;
            disp_is_on_q     <= disp_is_on_d;
            disp_on_start_q  <= disp_on_start_d;
            disp_off_start_q <= disp_off_start_d;
            write_start_q    <= write_start_d;
            update_start_q   <= update_start_d;
            wdata_q          <= wdata_d;
            waddr_q          <= waddr_d;
        end
    end

    assign dout             = dout_q;
    assign ack              = ack_q;
    assign busy             = (state_q != OFF) && (state_q != IDLE);
    assign disp_is_on       = disp_is_on_q;
    assign disp_on_start    = disp_on_start_q;
    assign disp_off_start   = disp_off_start_q;
    assign write_start      = write_start_q;
    assign write_ascii_data = wdata_q;
    assign write_base_addr  = waddr_q;
    assign update_start     = update_start_q;
    assign update_clear     = 1'b0;

endmodule

// File: doc/oled_text_sched.md
Name: oled_text_sched

Overview:
Scheduler that owns the OLED character controller's command interface. It keeps a 4x16 character shadow buffer that a host can read and write. It tracks which rows are dirty, and sequences the controller's power-on/off, per-character write and display-update handshakes. The host writes characters at any time; the block batches dirty rows into rate-limited repaints.

Parameters:
REFRESH_CYCLES, 5000000, minimum clocks between the starts of successive repaints.
ACK_TIMEOUT, 16, clocks to wait for a *_ready deassert after a start pulse before treating the operation as already complete.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
cs  input  1  host select
we  input  1  host write enable (1=write, 0=read)
addr  input  6  character index {row[1:0], col[3:0]}
din  input  8  host write data (ASCII)
dout  output  8  host read data, registered
ack  output  1  host access acknowledge, 1-cycle pulse
en  input  1  display enable request (level)
busy  output  1  high in any state other than OFF or IDLE
disp_is_on  output  1  high from power-on completion until power-off start
disp_on_start  output  1  controller power-on pulse
disp_on_ready  input  1  controller power-on available/done
disp_off_start  output  1  controller power-off pulse
disp_off_ready  input  1  controller power-off available/done
write_start  output  1  character write pulse
write_ascii_data  output  8  character code
write_base_addr  output  9  {row[1:0], col[3:0], 3'b000}
write_ready  input  1  controller write available/done
update_start  output  1  display update pulse
update_clear  output  1  always 0 in this block
update_ready  input  1  controller update available/done

Behaviour:
- Reset values: every output is 0, the buffer holds all 0x20, dirty=4'h0, the refresh counter is 0, state=OFF.
- Host access: on cs in cycle t, ack is high at t+1.
  - Write: buf[addr]<=din and dirty[addr[5:4]]<=1.
  - Read: dout=buf[addr] at t+1.
  - cs held high produces one access per cycle. The host must drop cs for back-to-back distinct accesses.
- Host accesses are served in every state. The FSM never stalls the host.
- Dirty set/clear collision: when a host write and a scheduler clear hit the same row in one cycle, set wins, so the row is repainted again.
- Refresh counter: decrements to 0 and saturates there. It reloads to REFRESH_CYCLES-1 when a repaint starts.
- Generic handshake for each op X (on, off, write, update):
  - Assert X_start for exactly 1 cycle, then enter X_ACK.
  - In X_ACK: X_ready=0 moves to X_WT. If ACK_TIMEOUT cycles pass with X_ready still 1, the op is complete.
  - In X_WT: X_ready=1 means the op is complete.
- FSM states: OFF, ON_ACK, ON_WT, IDLE, SEL, WR, WR_ACK, WR_WT, UPD_ACK, UPD_WT, OFF_ACK, OFF_WT.
- OFF: en & disp_on_ready pulses disp_on_start. On completion, set dirty=4'hF and disp_is_on=1, then go to IDLE.
- IDLE, priority order:
  1. !en & disp_off_ready: clear disp_is_on, pulse disp_off_start, go to OFF_ACK. Off completion returns to OFF.
  2. dirty!=0 and refresh counter==0: reload the counter, go to SEL.
- SEL: latch row r = lowest set dirty bit, clear dirty[r], set col=0, go to WR.
- WR: write_ascii_data=buf[{r,col}], write_base_addr={r,col,3'b0}, pulse write_start.
  - Data and address are held stable from WR until write completion.
- Write completion:
  - col!=15: col+1, back to WR.
  - col==15 and dirty!=0: back to SEL.
  - Otherwise pulse update_start with update_clear=0 and go to UPD_ACK.
- Update completion returns to IDLE. A full repaint is 64 writes plus 1 update.
- en deasserted mid-repaint: the repaint runs to completion, then IDLE performs power-off.
- en reasserted during OFF_ACK/OFF_WT: power-off completes first, then the normal OFF rule applies.
- Character data is sampled from the buffer at WR. A host write after that sample re-dirties the row.
- Reset asserted mid-operation: immediate return to reset values, all start pulses drop. The controller is re-sequenced from OFF.

Test Plan:
- Reset, en=1, disp_on_ready=1, ready drops 3 cycles then rises -> one disp_on_start pulse; then 64 write_start pulses with write_base_addr 0x000,0x008,...,0x1F8, all data 0x20; then one update_start; busy falls at end.
- In IDLE with counter expired, write addr=0x25 din=0x41 -> ack next cycle; one row-2 repaint of 16 writes, base addrs 0x100..0x178, data 0x41 only at 0x128; then update_start.
- During the write of row 1 col 7, host writes addr=0x13 -> row 1 is repainted a second time before update_start; 32 writes total.
- Model write_ready never dropping (instant op) -> each write advances after exactly ACK_TIMEOUT=16 cycles; no hang.
- Drop en mid-repaint -> remaining writes and the update complete, then one disp_off_start; disp_is_on falls at that pulse; state reaches OFF.
- Assert rst low while in WR_WT -> all outputs 0 asynchronously; after release the buffer reads 0x20 at every address and dirty=0.
